ahb_matrix_input_stage: RTL

//  Upstream neighbour of the per-slave output arbiters in the AHB bus matrix; one per master port.

---
 rtl/ahb_matrix_pkg.sv | 43 ++++
 rtl/ahb_instage_hold_reg.sv | 57 +++++
 rtl/ahb_matrix_input_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ahb_matrix_pkg.sv
// Shared AHB encodings and types for the bus-matrix input stage.
package ahb_matrix_pkg;

    localparam int AHB_ADDR_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    // Address-phase control fields; the address itself is kept separate so its width stays a parameter.
    typedef struct packed {
        htrans_t    trans;
        logic       write;
        logic [2:0] size;
        hburst_t    burst;
        logic [3:0] prot;
        logic       mastlock;
    } ctrl_t;

    function automatic logic is_fixed_burst(input hburst_t burst);
        return (burst != HBURST_SINGLE) && (burst != HBURST_INCR);
    endfunction

endpackage

// File: rtl/ahb_instage_hold_reg.sv
// Address-phase capture register and pending flag for one bus-matrix master port.
module ahb_instage_hold_reg
    import ahb_matrix_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              new_tran,
    input  logic              addr_accept,
    input  logic [ADDR_W-1:0] live_addr,
    input  ctrl_t             live_ctrl,
    output logic [ADDR_W-1:0] held_addr,
    output ctrl_t             held_ctrl,
    output logic              pend
);

    logic [ADDR_W-1:0] held_addr_q, held_addr_d;
    ctrl_t             held_ctrl_q, held_ctrl_d;
    logic              pend_q, pend_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        held_addr_d = held_addr_q;
        held_ctrl_d = held_ctrl_q;
        pend_d      = pend_q;
        if (new_tran) begin
            held_addr_d = live_addr;
            held_ctrl_d = live_ctrl;
        end
        // Clearing wins: the master is stalled while pending, so a fresh transfer cannot overlap.
        if (pend_q && addr_accept) begin
            pend_d = 1'b0;
        end else if (new_tran && !addr_accept) begin
            pend_d = 1'b1;
        end
    end

    // NOTE: held registers are reset too, so a held view after reset reads as an IDLE transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_addr_q <= '0;
            held_ctrl_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            held_addr_q <= held_addr_d;
            held_ctrl_q <= held_ctrl_d;
            pend_q      <= pend_d;
        end
    end

    assign held_addr = held_addr_q;
    assign held_ctrl = held_ctrl_q;
    assign pend      = pend_q;

endmodule

// File: rtl/ahb_matrix_input_stage.sv
// AHB bus-matrix input stage: holds a stalled address phase and returns the data-phase response.
// Optional stall counter enabled by defining AHB_MATRIX_INSTAGE_STALL_CNT_EN.
module ahb_matrix_input_stage
    import ahb_matrix_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    input  logic              addr_accept,
    input  logic              dp_active,
    input  logic              dp_readyout,
    input  logic              dp_resp,
    output logic              sel_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [1:0]        trans_out,
    output logic              write_out,
    output logic [2:0]        size_out,
    output logic [2:0]        burst_out,
    output logic [3:0]        prot_out,
    output logic              mastlock_out,
    output logic              held_tran
`ifdef AHB_MATRIX_INSTAGE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    logic              new_tran;
    ctrl_t             live_ctrl;
    ctrl_t             held_ctrl;
    logic [ADDR_W-1:0] held_addr;
    logic              pend;

    assign new_tran = HSELS & HREADYS & HTRANSS[1];

    always_comb begin
        live_ctrl.trans    = htrans_t'(HTRANSS);
        live_ctrl.write    = HWRITES;
        live_ctrl.size     = HSIZES;
        live_ctrl.burst    = hburst_t'(HBURSTS);
        live_ctrl.prot     = HPROTS;
        live_ctrl.mastlock = HMASTLOCKS;
    end

    ahb_instage_hold_reg #(.ADDR_W(ADDR_W)) u_hold_reg (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .new_tran    (new_tran),
        .addr_accept (addr_accept),
        .live_addr   (HADDRS),
        .live_ctrl   (live_ctrl),
        .held_addr   (held_addr),
        .held_ctrl   (held_ctrl),
        .pend        (pend)
    );

    // A held beat restarts on the output side, so SEQ becomes NONSEQ and fixed bursts become INCR.
    always_comb begin
        sel_out      = HSELS;
        addr_out     = HADDRS;
        trans_out    = HTRANSS;
        write_out    = HWRITES;
        size_out     = HSIZES;
        burst_out    = HBURSTS;
        prot_out     = HPROTS;
        mastlock_out = HMASTLOCKS;
        if (pend) begin
            sel_out      = 1'b1;
            addr_out     = held_addr;
            trans_out    = (held_ctrl.trans == HTRANS_SEQ) ? HTRANS_NONSEQ : held_ctrl.trans;
            write_out    = held_ctrl.write;
            size_out     = held_ctrl.size;
            burst_out    = is_fixed_burst(held_ctrl.burst) ? HBURST_INCR : held_ctrl.burst;
            prot_out     = held_ctrl.prot;
            mastlock_out = held_ctrl.mastlock;
        end
    end

    assign held_tran = pend;

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        if (pend) begin
            HREADYOUTS = 1'b0;
        end else if (dp_active) begin
            HREADYOUTS = dp_readyout;
            HRESPS     = dp_resp;
        end
    end

`ifdef AHB_MATRIX_INSTAGE_STALL_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (pend && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule
